pll_ctrl: RTL and testbench

//  Fabric-side controller for one SB_PLL40_PAD-style PLL: the initiator that drives the PLL's control and test pins.
//  - Sequences RESETB and BYPASS, and supervises LOCK with a stability filter and a timeout.
//  - Writes DYNAMICDELAY through a valid/ready request port.
//  - Masters the PLL test scan chain (SCLK/SDI out, SDO in).
//  - Sits beside the PLL instance in the top level; the host logic sees only status bits and two request ports.

---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/pll_scan_shift.sv | 72 +++++++
 rtl/pll_ctrl.sv | 151 +++++++++++++++
 tb/tb_pll_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and width helpers for the PLL controller
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2
    } pll_state_t;

    localparam int DEF_RESET_CYCLES = 16;
    localparam int DEF_LOCK_STABLE  = 8;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    localparam int DEF_SCAN_BITS    = 26;
    localparam int DEF_SCLK_DIV     = 4;

    // Bits needed for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_scan_shift.sv
// rtl/pll_scan_shift.sv - PLL test scan chain master with SCLK divider
module pll_scan_shift
    import pll_ctrl_pkg::*;
#(
    parameter int SCAN_BITS = DEF_SCAN_BITS,
    parameter int SCLK_DIV  = DEF_SCLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SCAN_BITS-1:0] wdata,
    output logic [SCAN_BITS-1:0] rdata,
    output logic                 busy,
    output logic                 sclk,
    output logic                 sdi,
    input  logic                 sdo
);

    localparam int DW = cnt_w(SCLK_DIV);
    localparam int BW = cnt_w(SCAN_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SCAN_BITS - 1);

    logic [SCAN_BITS-1:0] tx;
    logic [SCAN_BITS-1:0] rx;
    logic [DW-1:0]        div;
    logic [BW-1:0]        bitn;

    // The MSB of the transmit register is the SDI pin; it only moves on SCLK falls.
    assign sdi = tx[SCAN_BITS-1];

    // Half-period divider: low phase then high phase per bit, SDO captured on the rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx    <= '0;
            rx    <= '0;
            rdata <= '0;
            div   <= '0;
            bitn  <= '0;
            busy  <= 1'b0;
            sclk  <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                tx   <= wdata;
                rx   <= '0;
                div  <= '0;
                bitn <= '0;
                busy <= 1'b1;
                sclk <= 1'b0;
            end
        end else if (div != DIV_LAST) begin
            div <= div + 1'b1;
        end else begin
            div <= '0;
            if (!sclk) begin
                sclk <= 1'b1;
                rx   <= {rx[SCAN_BITS-2:0], sdo};
            end else begin
                sclk <= 1'b0;
                if (bitn == BIT_LAST) begin
                    busy  <= 1'b0;
                    rdata <= rx;
                    tx    <= '0;
                end else begin
                    bitn <= bitn + 1'b1;
                    tx   <= {tx[SCAN_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/pll_ctrl.sv
// rtl/pll_ctrl.sv - PLL reset/bypass/lock supervisor, delay port and scan master
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int         RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int         LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int         LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter logic [7:0] DLY_INIT     = 8'h00,
    parameter int         SCAN_BITS    = DEF_SCAN_BITS,
    parameter int         SCLK_DIV     = DEF_SCLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 pll_resetb,
    output logic                 pll_bypass,
    output logic [7:0]           pll_dynamicdelay,
    input  logic                 pll_lock,
    output logic                 pll_sclk,
    output logic                 pll_sdi,
    input  logic                 pll_sdo,
    input  logic                 dly_valid,
    input  logic [7:0]           dly_data,
    output logic                 dly_ready,
    input  logic                 scan_start,
    input  logic [SCAN_BITS-1:0] scan_wdata,
    output logic [SCAN_BITS-1:0] scan_rdata,
    output logic                 scan_busy,
    output logic                 locked,
    output logic                 lock_lost,
    output logic                 lock_timeout
);

    localparam int RC_W = cnt_w(RESET_CYCLES);
    localparam int ST_W = cnt_w(LOCK_STABLE);
    localparam int TO_W = cnt_w(LOCK_TIMEOUT);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    pll_state_t      state, next_state;
    logic [RC_W-1:0] rcnt;
    logic [ST_W-1:0] stable;
    logic [TO_W-1:0] tcnt;
    logic            lock_meta, lock_sync;
    logic            timeout_hit, lost_hit, dly_take;
    logic            resetb_d, bypass_d, locked_d;

    // Two-flop synchroniser for the asynchronous PLL LOCK pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    // Next-state: stability beats timeout; lock loss beats a delay handshake.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        lost_hit    = 1'b0;
        dly_take    = 1'b0;
        case (state)
            RESET: begin
                if (rcnt == RC_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_sync && stable == ST_LAST) begin
                    next_state = LOCKED;
                end else if (tcnt == TO_LAST) begin
                    next_state  = RESET;
                    timeout_hit = 1'b1;
                end
            end
            LOCKED: begin
                if (!lock_sync) begin
                    next_state = RESET;
                    lost_hit   = 1'b1;
                end else if (dly_valid && dly_ready) begin
                    next_state = WAIT_LOCK;
                    dly_take   = 1'b1;
                end
            end
            default: next_state = RESET;
        endcase
    end

    // Output decode from the upcoming state so the pins are registered with it.
    always_comb begin
        resetb_d = (next_state != RESET);
        bypass_d = (next_state != LOCKED);
        locked_d = (next_state == LOCKED);
    end

    // State, phase counters and registered PLL-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RESET;
            rcnt             <= '0;
            stable           <= '0;
            tcnt             <= '0;
            pll_resetb       <= 1'b0;
            pll_bypass       <= 1'b1;
            pll_dynamicdelay <= DLY_INIT;
            locked           <= 1'b0;
            dly_ready        <= 1'b0;
            lock_lost        <= 1'b0;
            lock_timeout     <= 1'b0;
        end else begin
            state        <= next_state;
            pll_resetb   <= resetb_d;
            pll_bypass   <= bypass_d;
            locked       <= locked_d;
            dly_ready    <= locked_d;
            lock_lost    <= lost_hit;
            lock_timeout <= timeout_hit;
            if (dly_take) pll_dynamicdelay <= dly_data;
            case (state)
                RESET: rcnt <= (next_state == RESET) ? rcnt + 1'b1 : '0;
                WAIT_LOCK: begin
                    if (next_state != WAIT_LOCK) begin
                        stable <= '0;
                        tcnt   <= '0;
                    end else begin
                        stable <= lock_sync ? stable + 1'b1 : '0;
                        tcnt   <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pll_scan_shift #(
        .SCAN_BITS (SCAN_BITS),
        .SCLK_DIV  (SCLK_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .start (scan_start),
        .wdata (scan_wdata),
        .rdata (scan_rdata),
        .busy  (scan_busy),
        .sclk  (pll_sclk),
        .sdi   (pll_sdi),
        .sdo   (pll_sdo)
    );

endmodule

// File: tb/tb_pll_ctrl.sv
// tb/tb_pll_ctrl.sv - self-checking bench for pll_ctrl
module tb_pll_ctrl;

    localparam int         RC  = 16;
    localparam int         LS  = 8;
    localparam int         LT  = 4096;
    localparam logic [7:0] DI  = 8'h00;
    localparam int         SB  = 26;
    localparam int         SD  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_resetb, pll_bypass, pll_sclk, pll_sdi, pll_sdo;
    logic [7:0]    pll_dynamicdelay;
    logic          pll_lock = 1'b0;
    logic          dly_valid = 1'b0;
    logic [7:0]    dly_data = 8'h00;
    logic          dly_ready;
    logic          scan_start = 1'b0;
    logic [SB-1:0] scan_wdata = '0;
    logic [SB-1:0] scan_rdata;
    logic          scan_busy, locked, lock_lost, lock_timeout;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_delay = DI;

    assign pll_sdo = pll_sdi;

    always #5 clk = ~clk;

    pll_ctrl #(
        .RESET_CYCLES (RC), .LOCK_STABLE (LS), .LOCK_TIMEOUT (LT),
        .DLY_INIT (DI), .SCAN_BITS (SB), .SCLK_DIV (SD)
    ) dut (
        .clk (clk), .rst (rst),
        .pll_resetb (pll_resetb), .pll_bypass (pll_bypass),
        .pll_dynamicdelay (pll_dynamicdelay), .pll_lock (pll_lock),
        .pll_sclk (pll_sclk), .pll_sdi (pll_sdi), .pll_sdo (pll_sdo),
        .dly_valid (dly_valid), .dly_data (dly_data), .dly_ready (dly_ready),
        .scan_start (scan_start), .scan_wdata (scan_wdata),
        .scan_rdata (scan_rdata), .scan_busy (scan_busy),
        .locked (locked), .lock_lost (lock_lost), .lock_timeout (lock_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for resetb to reach a level; an expired bound is a failure.
    task automatic wait_resetb(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (pll_resetb !== lvl && n < bound) begin tick(); n++; end
        checks++;
        if (pll_resetb !== lvl) begin
            errors++; $display("FAIL %s: resetb=%b required %b within %0d cycles", tag, pll_resetb, lvl, bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks += 7;
        if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rst_resetb: got %b want 0", pll_resetb); end
        if (pll_bypass !== 1'b1) begin errors++; $display("FAIL rst_bypass: got %b want 1", pll_bypass); end
        if (pll_dynamicdelay !== DI) begin errors++; $display("FAIL rst_delay: got %h want %h", pll_dynamicdelay, DI); end
        if ({pll_sclk, pll_sdi, scan_busy} !== 3'b000) begin errors++; $display("FAIL rst_scan_pins: got %b want 000", {pll_sclk, pll_sdi, scan_busy}); end
        if (scan_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", scan_rdata); end
        if ({dly_ready, locked} !== 2'b00) begin errors++; $display("FAIL rst_ready_locked: got %b want 00", {dly_ready, locked}); end
        if ({lock_lost, lock_timeout} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {lock_lost, lock_timeout}); end
        rst = 1'b0;
        begin
            int n = 0;
            while (pll_resetb === 1'b0 && n < 100) begin tick(); n++; end
            checks += 2;
            if (n != RC) begin errors++; $display("FAIL rst_release_len: resetb low %0d cycles want %0d", n, RC); end
            if (pll_bypass !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL wait_lock_outs: bypass=%b locked=%b want 1/0", pll_bypass, locked); end
        end
    endtask

    task automatic test_lock_basic();
        int n = 0;
        pll_lock = 1'b1;
        while (locked !== 1'b1 && n < 100) begin tick(); n++; end
        checks += 2;
        if (n != LS + 2) begin errors++; $display("FAIL lock_latency: %0d cycles want %0d", n, LS + 2); end
        if (pll_bypass !== 1'b0 || dly_ready !== 1'b1) begin errors++; $display("FAIL locked_outs: bypass=%b ready=%b want 0/1", pll_bypass, dly_ready); end
    endtask

    task automatic test_dly();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            int n;
            d = (i == 0) ? 8'h5A : 8'($urandom);
            dly_valid = 1'b1; dly_data = d;
            tick();
            dly_valid = 1'b0;
            exp_delay = d;
            checks += 3;
            if (pll_dynamicdelay !== exp_delay) begin errors++; $display("FAIL dly_value: got %h want %h", pll_dynamicdelay, exp_delay); end
            if (locked !== 1'b0 || dly_ready !== 1'b0) begin errors++; $display("FAIL dly_unlock: locked=%b ready=%b want 0/0", locked, dly_ready); end
            if (pll_resetb !== 1'b1) begin errors++; $display("FAIL dly_no_resetb: resetb=%b want 1", pll_resetb); end
            n = 0;
            while (locked !== 1'b1 && n < 100) begin tick(); n++; end
            checks++;
            if (n < LS || n > LS + 2) begin errors++; $display("FAIL dly_relock: %0d cycles want %0d..%0d", n, LS, LS + 2); end
        end
    endtask

    task automatic test_lock_lost();
        int low;
        pll_lock = 1'b0;
        tick(); tick();
        dly_valid = 1'b1; dly_data = ~exp_delay;
        tick();
        dly_valid = 1'b0;
        checks += 3;
        if (lock_lost !== 1'b1) begin errors++; $display("FAIL lost_pulse: got %b want 1", lock_lost); end
        if (pll_dynamicdelay !== exp_delay) begin errors++; $display("FAIL lost_delay_kept: got %h want %h", pll_dynamicdelay, exp_delay); end
        if ({locked, dly_ready, pll_resetb, pll_bypass} !== 4'b0001) begin errors++; $display("FAIL lost_outs: got %b want 0001", {locked, dly_ready, pll_resetb, pll_bypass}); end
        low = 1;
        tick();
        checks++;
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL lost_one_cycle: got %b want 0", lock_lost); end
        while (pll_resetb === 1'b0 && low < 100) begin low++; tick(); end
        checks++;
        if (low != RC) begin errors++; $display("FAIL lost_reset_len: %0d want %0d", low, RC); end
    endtask

    task automatic test_glitch();
        for (int t = 0; t < 3; t++) begin
            int h, l, n;
            h = $urandom_range(LS - 1, 1);
            l = $urandom_range(4, 1);
            wait_resetb(1'b1, 200, "glitch_entry");
            pll_lock = 1'b1; repeat (h) tick();
            pll_lock = 1'b0; repeat (l) tick();
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL glitch_early: locked=%b want 0 (h=%0d l=%0d)", locked, h, l); end
            pll_lock = 1'b1;
            n = 0;
            while (locked !== 1'b1 && n < 100) begin tick(); n++; end
            checks++;
            if (n != LS + 2) begin errors++; $display("FAIL glitch_latency: %0d want %0d (h=%0d l=%0d)", n, LS + 2, h, l); end
            if (t != 2) begin
                pll_lock = 1'b0;
                wait_resetb(1'b0, 20, "glitch_drop");
            end
        end
    endtask

    task automatic test_timeout();
        pll_lock = 1'b0;
        wait_resetb(1'b0, 20, "to_drop");
        wait_resetb(1'b1, 100, "to_entry");
        for (int r = 0; r < 2; r++) begin
            int n = 0, low = 1;
            while (lock_timeout !== 1'b1 && n < LT + 100) begin tick(); n++; end
            checks += 2;
            if (n != LT) begin errors++; $display("FAIL timeout_len: %0d want %0d", n, LT); end
            if (pll_resetb !== 1'b0) begin errors++; $display("FAIL timeout_resetb: got %b want 0", pll_resetb); end
            tick();
            checks++;
            if (lock_timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %b want 0", lock_timeout); end
            while (pll_resetb === 1'b0 && low < 100) begin low++; tick(); end
            checks++;
            if (low != RC) begin errors++; $display("FAIL timeout_reset_len: %0d want %0d", low, RC); end
        end
    endtask

    task automatic test_scan();
        for (int s = 0; s < 4; s++) begin
            logic [SB-1:0] w, prev_rd, seen;
            int busy_n, pulses, guard;
            logic prev_sclk;
            w = (s == 0) ? 26'h2AAAAAA : SB'($urandom);
            prev_rd = scan_rdata;
            scan_start = 1'b1; scan_wdata = w;
            tick();
            scan_start = 1'b0;
            busy_n = (scan_busy === 1'b1) ? 1 : 0;
            pulses = 0; seen = '0; prev_sclk = pll_sclk; guard = 0;
            while (scan_busy === 1'b1 && guard < 1000) begin
                if (busy_n == 50) begin scan_start = 1'b1; scan_wdata = ~w; end
                else scan_start = 1'b0;
                tick();
                guard++;
                if (pll_sclk === 1'b1 && prev_sclk === 1'b0) begin
                    pulses++; seen = {seen[SB-2:0], pll_sdi};
                end
                prev_sclk = pll_sclk;
                if (scan_busy === 1'b1) begin
                    busy_n++;
                    if (scan_rdata !== prev_rd) begin
                        checks++; errors++;
                        $display("FAIL scan_rdata_early: got %h want %h", scan_rdata, prev_rd);
                    end
                end
            end
            scan_start = 1'b0;
            checks += 5;
            if (busy_n != SB * 2 * SD) begin errors++; $display("FAIL scan_busy_len: %0d want %0d", busy_n, SB * 2 * SD); end
            if (pulses != SB) begin errors++; $display("FAIL scan_pulses: %0d want %0d", pulses, SB); end
            if (seen !== w) begin errors++; $display("FAIL scan_sdi_order: got %h want %h", seen, w); end
            if (scan_rdata !== w) begin errors++; $display("FAIL scan_rdata: got %h want %h", scan_rdata, w); end
            if (pll_sclk !== 1'b0) begin errors++; $display("FAIL scan_sclk_idle: got %b want 0", pll_sclk); end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        pll_lock = 1'b1;
        while (locked !== 1'b1 && n < LT + 200) begin tick(); n++; end
        dly_valid = 1'b1; dly_data = 8'hC3;
        tick();
        dly_valid = 1'b0;
        n = 0;
        while (locked !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (locked !== 1'b1 || pll_dynamicdelay !== 8'hC3) begin errors++; $display("FAIL pre_rst_state: locked=%b delay=%h want 1/c3", locked, pll_dynamicdelay); end
        scan_start = 1'b1; scan_wdata = SB'($urandom) | 26'h1;
        tick();
        scan_start = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        checks += 4;
        if ({pll_resetb, pll_bypass, locked, dly_ready} !== 4'b0100) begin errors++; $display("FAIL midrst_fsm: got %b want 0100", {pll_resetb, pll_bypass, locked, dly_ready}); end
        if (pll_dynamicdelay !== DI) begin errors++; $display("FAIL midrst_delay: got %h want %h", pll_dynamicdelay, DI); end
        if ({scan_busy, pll_sclk, pll_sdi} !== 3'b000) begin errors++; $display("FAIL midrst_scan: got %b want 000", {scan_busy, pll_sclk, pll_sdi}); end
        if (scan_rdata !== '0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", scan_rdata); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_dly();
        test_lock_lost();
        test_glitch();
        test_timeout();
        test_scan();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
